// File: rtl/divider_32_if.sv
// Purpose: operand/result bundle between the execution-stage control and divider_32.
// Latency: none (wires only).
// Backpressure: none; the requester must watch busy and only pulse start when it is low.
// Ports: start/is_signed/dividend/divisor go requester -> divider;
//        quotient/remainder/busy/done/div_by_zero go divider -> requester.
interface divider_32_if;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/divider_32.sv
// Purpose: iterative 32-bit DIV/DIVU, restoring shift/subtract, one quotient bit per cycle.
// Latency: fixed 34 cycles from the accepting edge to the end of the one-cycle done pulse.
// Backpressure: start is ignored while busy (no queuing); start during the done cycle is accepted.
// Ports: clk, rst_n (async active-low); bus (divider_32_if.slave) carries start/is_signed/
//        dividend/divisor in and registered quotient (LO)/remainder (HI)/busy/done/div_by_zero out.
module divider_32 (
   input  logic          clk,
   input  logic          rst_n,
   divider_32_if.slave   bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] SIGN = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state;
   logic [4:0]  step;
   logic [32:0] acc;          // partial remainder
   logic [31:0] qreg;         // dividend magnitude shifting out, quotient bits shifting in
   logic [31:0] dvsr;         // divisor magnitude
   logic        neg_q;
   logic        neg_r;

   logic [31:0] quotient_r;
   logic [31:0] remainder_r;
   logic        busy_r;
   logic        done_r;
   logic        dz_r;

   logic        accept;
   logic        dvd_neg;
   logic        dvs_neg;
   logic [31:0] dvd_abs;
   logic [31:0] dvs_abs;
   logic [33:0] trial;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   assign accept  = bus.start && ((state == IDLE) || (state == DONE));
   assign dvd_neg = bus.is_signed & bus.dividend[31];
   assign dvs_neg = bus.is_signed & bus.divisor[31];
   // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
   assign dvd_abs = dvd_neg ? -bus.dividend : bus.dividend;
   assign dvs_abs = dvs_neg ? -bus.divisor  : bus.divisor;

   // Shifted accumulator minus divisor; one extra bit so the borrow is visible.
   assign trial = {acc, qreg[31]} - {2'b00, dvsr};

   assign q_fix = neg_q ? -qreg : qreg;
   // With a zero divisor every trial succeeds, so acc ends holding |dividend| and
   // the sign fix-up here reproduces the raw dividend as the remainder.
   assign r_fix = neg_r ? -acc[31:0] : acc[31:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         step        <= 5'd0;
         acc         <= 33'd0;
         qreg        <= 32'd0;
         dvsr        <= 32'd0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         quotient_r  <= 32'd0;
         remainder_r <= 32'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         dz_r        <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (accept) begin
                  neg_q  <= dvd_neg ^ dvs_neg;
                  neg_r  <= dvd_neg;
                  qreg   <= dvd_abs;
                  dvsr   <= dvs_abs;
                  acc    <= 33'd0;
                  step   <= 5'd0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               if (!trial[33]) begin
                  acc  <= trial[32:0];
                  qreg <= {qreg[30:0], 1'b1};
               end else begin
                  acc  <= {acc[31:0], qreg[31]};
                  qreg <= {qreg[30:0], 1'b0};
               end
               step <= step + 5'd1;
               if (step == 5'd31) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               if (dvsr == 32'd0) begin
                  quotient_r <= 32'hFFFF_FFFF;
                  dz_r       <= 1'b1;
               end else begin
                  quotient_r <= q_fix;
                  dz_r       <= 1'b0;
               end
               remainder_r <= r_fix;
               busy_r      <= 1'b0;
               done_r      <= 1'b1;
               state       <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_divider_32.sv
// Purpose: directed self-checking bench for divider_32.
// Latency: expects done exactly 34 cycles after the start edge, busy for 33.
// Backpressure: exercises start while busy and start during the done cycle.
module tb_divider_32;

   logic clk;
   logic rst_n;

   divider_32_if bus ();

   divider_32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] q_o;
   logic [31:0] r_o;
   logic        dz_o;
   int          lat;
   int          bcnt;

   // Drive one division and wait for done; lat is the negedge index of done
   // counted from the start edge (0 means it never came).
   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.dividend  = a;
      bus.divisor   = b;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.is_signed = ~sgn;
      bus.dividend  = 32'h1234_5678;
      bus.divisor   = 32'h0000_0003;
      lat  = 0;
      bcnt = 0;
      q_o  = 32'hDEAD_BEEF;
      r_o  = 32'hDEAD_BEEF;
      dz_o = 1'bx;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.busy) bcnt++;
         if (bus.done) begin
            lat  = k;
            q_o  = bus.quotient;
            r_o  = bus.remainder;
            dz_o = bus.div_by_zero;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd0;
      bus.divisor   = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (bus.quotient !== 32'd0) begin tests_failed++; $display("FAIL reset_quotient: got %h want 0", bus.quotient); end
      tests_run++;
      if (bus.remainder !== 32'd0) begin tests_failed++; $display("FAIL reset_remainder: got %h want 0", bus.remainder); end
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      tests_run++;
      if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done); end
      tests_run++;
      if (bus.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dz: got %b want 0", bus.div_by_zero); end
   endtask

   task automatic test_unsigned_basic;
      do_div(1'b0, 32'd100, 32'd7);
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL u_latency: got %0d want 34", lat); end
      tests_run++;
      if (bcnt !== 33) begin tests_failed++; $display("FAIL u_busy_cycles: got %0d want 33", bcnt); end
      tests_run++;
      if (q_o !== 32'd14) begin tests_failed++; $display("FAIL u_quotient: got %h want %h", q_o, 32'd14); end
      tests_run++;
      if (r_o !== 32'd2) begin tests_failed++; $display("FAIL u_remainder: got %h want %h", r_o, 32'd2); end
      tests_run++;
      if (dz_o !== 1'b0) begin tests_failed++; $display("FAIL u_dz: got %b want 0", dz_o); end
      // done must be a single-cycle pulse with results held afterwards
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL u_done_pulse: got %b want 0", bus.done); end
      tests_run++;
      if (bus.quotient !== 32'd14) begin tests_failed++; $display("FAIL u_hold: got %h want %h", bus.quotient, 32'd14); end
   endtask

   task automatic test_signed;
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [31:0] eq [3];
      logic [31:0] er [3];
      va = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9};
      vb = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE};
      eq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
      er = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         do_div(1'b1, va[i], vb[i]);
         tests_run++;
         if (q_o !== eq[i]) begin tests_failed++; $display("FAIL signed_q[%0d]: got %h want %h", i, q_o, eq[i]); end
         tests_run++;
         if (r_o !== er[i]) begin tests_failed++; $display("FAIL signed_r[%0d]: got %h want %h", i, r_o, er[i]); end
      end
   endtask

   task automatic test_extremes;
      logic        vs [3];
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [31:0] eq [3];
      logic [31:0] er [3];
      vs = '{1'b0,         1'b1,         1'b0};
      va = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
      vb = '{32'd1,         32'hFFFF_FFFF, 32'd9};
      eq = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
      er = '{32'd0,         32'd0,         32'd5};
      for (int i = 0; i < 3; i++) begin
         do_div(vs[i], va[i], vb[i]);
         tests_run++;
         if (q_o !== eq[i]) begin tests_failed++; $display("FAIL extreme_q[%0d]: got %h want %h", i, q_o, eq[i]); end
         tests_run++;
         if (r_o !== er[i]) begin tests_failed++; $display("FAIL extreme_r[%0d]: got %h want %h", i, r_o, er[i]); end
         tests_run++;
         if (dz_o !== 1'b0) begin tests_failed++; $display("FAIL extreme_dz[%0d]: got %b want 0", i, dz_o); end
      end
   endtask

   task automatic test_div_zero;
      do_div(1'b1, 32'hFFFF_FFF9, 32'd0);
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL dz_latency: got %0d want 34", lat); end
      tests_run++;
      if (q_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dz_q: got %h want ffffffff", q_o); end
      tests_run++;
      if (r_o !== 32'hFFFF_FFF9) begin tests_failed++; $display("FAIL dz_r: got %h want fffffff9", r_o); end
      tests_run++;
      if (dz_o !== 1'b1) begin tests_failed++; $display("FAIL dz_flag: got %b want 1", dz_o); end
      do_div(1'b1, 32'd10, 32'd3);
      tests_run++;
      if (q_o !== 32'd3) begin tests_failed++; $display("FAIL dz_clear_q: got %h want 3", q_o); end
      tests_run++;
      if (r_o !== 32'd1) begin tests_failed++; $display("FAIL dz_clear_r: got %h want 1", r_o); end
      tests_run++;
      if (dz_o !== 1'b0) begin tests_failed++; $display("FAIL dz_clear_flag: got %b want 0", dz_o); end
   endtask

   task automatic test_start_while_busy;
      int k_done;
      @(negedge clk);
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      k_done = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 10) begin
            bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
         end else if (k == 11) begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            k_done = k;
            q_o = bus.quotient;
            r_o = bus.remainder;
            break;
         end
      end
      tests_run++;
      if (k_done !== 34) begin tests_failed++; $display("FAIL busy_start_latency: got %0d want 34", k_done); end
      tests_run++;
      if (q_o !== 32'd14) begin tests_failed++; $display("FAIL busy_start_q: got %h want %h", q_o, 32'd14); end
      tests_run++;
      if (r_o !== 32'd2) begin tests_failed++; $display("FAIL busy_start_r: got %h want %h", r_o, 32'd2); end
      // no queued second division
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL busy_start_noqueue: got %b want 0", bus.busy); end
   endtask

   task automatic test_back_to_back;
      int k1;
      int k2;
      @(negedge clk);
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd10;
      @(posedge clk);
      #1 bus.start = 1'b0;
      k1 = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done) begin
            k1 = k;
            q_o = bus.quotient;
            bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd81; bus.divisor = 32'd9;
            break;
         end
      end
      tests_run++;
      if (k1 !== 34) begin tests_failed++; $display("FAIL b2b_first_latency: got %0d want 34", k1); end
      tests_run++;
      if (q_o !== 32'd100) begin tests_failed++; $display("FAIL b2b_first_q: got %h want %h", q_o, 32'd100); end
      @(posedge clk);
      #1 bus.start = 1'b0;
      k2 = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            tests_run++;
            if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy_again: got %b want 1", bus.busy); end
         end
         if (bus.done) begin
            k2 = k;
            q_o = bus.quotient;
            r_o = bus.remainder;
            break;
         end
      end
      tests_run++;
      if (k2 !== 34) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d want 34", k2); end
      tests_run++;
      if (q_o !== 32'd9) begin tests_failed++; $display("FAIL b2b_second_q: got %h want 9", q_o); end
      tests_run++;
      if (r_o !== 32'd0) begin tests_failed++; $display("FAIL b2b_second_r: got %h want 0", r_o); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (16) @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      tests_run++;
      if (bus.quotient !== 32'd0) begin tests_failed++; $display("FAIL rstmid_q: got %h want 0", bus.quotient); end
      tests_run++;
      if (bus.remainder !== 32'd0) begin tests_failed++; $display("FAIL rstmid_r: got %h want 0", bus.remainder); end
      tests_run++;
      if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
         tests_failed++; $display("FAIL rstmid_flags: got done=%b dz=%b want 0 0", bus.done, bus.div_by_zero);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_div(1'b0, 32'd100, 32'd7);
      tests_run++;
      if (lat !== 34) begin tests_failed++; $display("FAIL rstmid_after_latency: got %0d want 34", lat); end
      tests_run++;
      if (q_o !== 32'd14) begin tests_failed++; $display("FAIL rstmid_after_q: got %h want %h", q_o, 32'd14); end
      tests_run++;
      if (r_o !== 32'd2) begin tests_failed++; $display("FAIL rstmid_after_r: got %h want %h", r_o, 32'd2); end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_extremes();
      test_div_zero();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/divider_32.md
# divider_32

Iterative 32-bit integer divider for the MIPS execution stage, the subtract-based inverse of the datapath's 32-bit adder. It implements DIV and DIVU with a one-quotient-bit-per-cycle restoring shift/subtract loop. It takes operands on a start pulse and returns quotient (LO) and remainder (HI) after a fixed latency. The control unit stalls on `busy` and writes HI/LO when `done` pulses.

## Interface
- No parameters; width fixed at 32.
- `clk` input 1 — sole clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — request a division; sampled only in IDLE or DONE.
- `is_signed` input 1 — 1 = DIV (two's complement), 0 = DIVU.
- `dividend` input 32 — numerator, captured on accepted start.
- `divisor` input 32 — denominator, captured on accepted start.
- `quotient` output 32 — LO result; holds until the next `done`.
- `remainder` output 32 — HI result; holds until the next `done`.
- `busy` output 1 — high while a division is in flight.
- `done` output 1 — one-cycle pulse when results are valid.
- `div_by_zero` output 1 — flag for the last result, updated with `done`.

## Operation
- States: IDLE, RUN, SIGN, DONE.
- **IDLE/DONE + `start`=1:**
  - Capture operand signs (only when `is_signed`).
  - Capture absolute values: dividend into the quotient shift register, divisor into a 32-bit register.
  - Clear the 33-bit partial-remainder accumulator and set the step counter to 0.
  - Go to RUN.
- **IDLE/DONE + `start`=0:** DONE goes to IDLE; IDLE stays in IDLE.
- **RUN, one step per cycle:**
  - Shift {acc, qreg} left by 1.
  - trial = acc − {1'b0, divisor}, computed at 33 bits.
  - If trial is non-negative (bit 32 = 0): acc ← trial and the shifted-in quotient bit = 1. Otherwise acc is unchanged and the bit = 0.
  - After step 31 (32 steps total), go to SIGN.
- **SIGN (one cycle):**
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative; the remainder takes the dividend's sign.
  - Load the `quotient`/`remainder` output registers and go to DONE.
- **DONE (one cycle):** `done`=1. Transitions as for IDLE above.
- **Divisor zero:**
  - Same latency as any other division.
  - SIGN overrides the results: quotient = 32'hFFFFFFFF, remainder = raw captured dividend, `div_by_zero`=1. Otherwise `div_by_zero`=0.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. The result wraps; no flag is raised.
- **Operand capture:**
  - Absolute value of 0x80000000 is 0x80000000, treated as unsigned magnitude; this works correctly.
  - Operand or `is_signed` changes after capture are ignored.
- **`start` while `busy`:** ignored, with no queuing and no effect on the current division.
- **Reset:** asserting `rst_n`=0 at any time, including mid-RUN, asynchronously forces IDLE and aborts the division.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_by_zero`=0, state IDLE, counter 0.
- `start` is sampled at edge E0.
- `busy`=1 from after E0 through the cycle ending at E33: RUN occupies E1..E32 and SIGN occupies E33.
- `done`=1 for exactly one cycle, between E33 and E34. `quotient`, `remainder` and `div_by_zero` become valid at E33 and are stable while `done`=1.
- Fixed latency: 34 cycles from the start edge to the end of the `done` cycle.
- `start` asserted during the `done` cycle is accepted at E34 (back-to-back, no bubble). `busy` is then high again after E34.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Unsigned basic:** DIVU 100 / 7 → `done` at E33–E34, q=14, r=2, `div_by_zero`=0; `busy` high for exactly 33 cycles.
- **Signed sign rules:**
  - DIV −7 / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF.
  - DIV 7 / −2 → q=0xFFFFFFFD, r=1.
  - DIV −7 / −2 → q=3, r=0xFFFFFFFF.
- **Extremes:**
  - DIVU 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0.
  - DIV 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
  - DIVU 5 / 9 → q=0, r=5.
- **Divide by zero:** DIV 0xFFFFFFF9 / 0 → q=0xFFFFFFFF, r=0xFFFFFFF9, `div_by_zero`=1, same 34-cycle latency. A following 10 / 3 clears the flag (q=3, r=1).
- **Handshake:**
  - Pulse `start` mid-RUN with different operands → ignored; the first result is unchanged.
  - `start` held during the `done` cycle → second division accepted immediately, with its `done` exactly 34 cycles later.
- **Reset mid-operation:** drop `rst_n` at step 15 → all outputs 0 and `busy`=0 immediately, without waiting for a clock. After release, a new 100 / 7 completes correctly.
